// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
//
// Purpose:
//   Sequencer plus multiply-accumulate stage that sits directly behind the two
//   dot-product operand memories (vector A and vector B). A start pulse issues
//   a run of lockstep read addresses to both memories. The engine consumes the
//   registered read data one element per cycle, accumulates the element-wise
//   products, and presents the final dot product with a one-cycle done pulse.
//
// Build option:
//   DOTP_SIGNED_EN - when defined, operands are two's-complement and each
//                    product is sign-extended into the accumulator. When
//                    undefined, operands are unsigned and products are
//                    zero-extended. Ports, latency and FSM are the same in
//                    both builds.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst_n      in   synchronous reset, ACTIVE-HIGH despite the name
//   start      in   single-cycle request, sampled only in IDLE
//   base_a     in   first element address in memory A
//   base_b     in   first element address in memory B
//   length     in   element count 0..2^ADDR_WIDTH, sampled with start
//   rd_en      out  read enable shared by both memories
//   rd_addr_a  out  memory A read address
//   rd_addr_b  out  memory B read address
//   rd_data_a  in   memory A data, valid the cycle after rd_en
//   rd_data_b  in   memory B data, same timing as rd_data_a
//   busy       out  high from the cycle after an accepted start through done
//   done       out  one-cycle pulse, result valid
//   result     out  final dot product, held until the next accepted start
//   dbg_state  out  current FSM state (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
//
// Handshake:
//   start is a request with no ready. It is accepted only in the cycle where
//   busy=0. While busy=1, start is ignored and has no effect. done marks the
//   single cycle in which result first shows the new dot product.
// -----------------------------------------------------------------------------
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  output logic [1:0]            dbg_state
);

  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q,  state_d;
  logic                  rd_en_q,  rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [ADDR_WIDTH:0]   len_q,    len_d;
  logic [ADDR_WIDTH:0]   cnt_q,    cnt_d;
  logic                  valid_q,  valid_d;
  logic [ACC_WIDTH-1:0]  acc_q,    acc_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;

  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_sum;

  // ---------------------------------------------------------------------------
  // Product, extended to the accumulator width. A narrower ACC_WIDTH simply
  // truncates, so the accumulator wraps modulo 2^ACC_WIDTH.
  // ---------------------------------------------------------------------------
`ifdef DOTP_SIGNED_EN
  logic signed [PW-1:0] op_a_s;
  logic signed [PW-1:0] op_b_s;
  logic signed [PW-1:0] prod_s;

  assign op_a_s   = PW'($signed(rd_data_a));
  assign op_b_s   = PW'($signed(rd_data_b));
  assign prod_s   = op_a_s * op_b_s;
  assign prod_ext = ACC_WIDTH'(prod_s);
`else
  logic [PW-1:0] op_a_u;
  logic [PW-1:0] op_b_u;
  logic [PW-1:0] prod_u;

  assign op_a_u   = PW'(rd_data_a);
  assign op_b_u   = PW'(rd_data_b);
  assign prod_u   = op_a_u * op_b_u;
  assign prod_ext = ACC_WIDTH'(prod_u);
`endif

  assign acc_sum = acc_q + prod_ext;
  assign cnt_inc = cnt_q + (ADDR_WIDTH+1)'(1);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_en_d  = rd_en_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    // valid is rd_en delayed by one cycle, matching the memory read latency.
    valid_d  = rd_en_q;
    acc_d    = valid_q ? acc_sum : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          if (length != '0) begin
            state_d  = S_ISSUE;
            rd_en_d  = 1'b1;
            addr_a_d = base_a;
            addr_b_d = base_b;
            len_d    = length;
          end else begin
            state_d  = S_DONE;
            result_d = '0;
          end
        end
      end

      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          // Natural wrap at 2^ADDR_WIDTH gives the modulo addressing.
          addr_a_d = addr_a_q + ADDR_WIDTH'(1);
          addr_b_d = addr_b_q + ADDR_WIDTH'(1);
        end
      end

      S_DRAIN: begin
        // The last element's data is being consumed this cycle, so the final
        // sum is acc_d and is captured straight into the result register.
        state_d  = S_DONE;
        result_d = acc_d;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      rd_en_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_en     = rd_en_q;
  assign rd_addr_a = addr_a_q;
  assign rd_addr_b = addr_b_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dot_product_engine.sv
module tb_dot_product_engine;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int ACW = 2*DW + AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic           start;
  logic [AW-1:0]  base_a, base_b;
  logic [AW:0]    length;
  logic           rd_en;
  logic [AW-1:0]  rd_addr_a, rd_addr_b;
  logic [DW-1:0]  rd_data_a, rd_data_b;
  logic           busy, done;
  logic [ACW-1:0] result;
  logic [1:0]     dbg_state;

  dot_product_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_a    (base_a),
    .base_b    (base_b),
    .length    (length),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Operand memories: registered read, data valid the cycle after rd_en.
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  initial begin
    rd_data_a = 8'h5A;
    rd_data_b = 8'hA5;
  end

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [ACW-1:0]  exp_q[$];
  int              exp_cyc_q[$];
  logic [2*AW-1:0] exp_addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected address pair on every rd_en and an expected
  // result/cycle on every done.
  always @(negedge clk) begin
    logic [2*AW-1:0] ea;
    logic [ACW-1:0]  er;
    int              ec;
    if (rd_en) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_rd_en", 32'(rd_en), 32'd0);
      end else begin
        ea = exp_addr_q.pop_front();
        check("rd_addr_a", 32'(rd_addr_a), 32'(ea[2*AW-1:AW]));
        check("rd_addr_b", 32'(rd_addr_b), 32'(ea[AW-1:0]));
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        er = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 32'(result), 32'(er));
        check("done_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge; return at the negedge of cycle 1)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                       input logic [AW:0] len, input logic [ACW-1:0] exp_res,
                       input int n_addr, input bit expect_done);
    logic [AW-1:0] a, b;
    int s;
    base_a = ba;
    base_b = bb;
    length = len;
    start  = 1'b1;
    s      = cyc;
    a      = ba;
    b      = bb;
    for (int i = 0; i < n_addr; i++) begin
      exp_addr_q.push_back({a, b});
      a = a + AW'(1);
      b = b + AW'(1);
    end
    if (expect_done) begin
      exp_q.push_back(exp_res);
      exp_cyc_q.push_back((len == 0) ? s + 1 : s + int'(len) + 2);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_t1();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = (i < 4) ? DW'(i + 1) : 8'h00;
      mem_b[i] = (i < 4) ? DW'(i + 5) : 8'h00;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [ACW-1:0] exp_ff, exp_sgn;

  initial begin
`ifdef DOTP_SIGNED_EN
    exp_ff  = 20'h00010;   // (-1)*(-1)*16
    exp_sgn = 20'hFFFF5;   // -1*3 + -2*4 = -11
`else
    exp_ff  = 20'hFE010;   // 255*255*16 = 1040400
    exp_sgn = 20'd1781;    // 255*3 + 254*4
`endif
    rst_n  = 1'b1;
    start  = 1'b0;
    base_a = '0;
    base_b = '0;
    length = '0;
    load_t1();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_en",  32'(rd_en), 32'd0);
    check("rst_addr_a", 32'(rd_addr_a), 32'd0);
    check("rst_addr_b", 32'(rd_addr_b), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_state",  32'(dbg_state), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // Basic run: {1,2,3,4}.{5,6,7,8} = 70, done in cycle 6
    issue(4'd0, 4'd0, 5'd4, 20'd70, 4, 1'b1);
    check("t1_busy_c1",  32'(busy), 32'd1);
    check("t1_rden_c1",  32'(rd_en), 32'd1);
    check("t1_state_c1", 32'(dbg_state), 32'd1);
    repeat (6) @(negedge clk);
    check("t1_busy_c7", 32'(busy), 32'd0);

    // Start re-pulsed in cycle 2 of a run: ignored, same single result
    @(negedge clk);
    issue(4'd0, 4'd0, 5'd4, 20'd70, 4, 1'b1);
    @(negedge clk);
    base_a = 4'd5;
    base_b = 4'd5;
    length = 5'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_busy_end", 32'(busy), 32'd0);

    // Back-to-back: second start in the cycle after done
    @(negedge clk);
    issue(4'd0, 4'd0, 5'd2, 20'd17, 2, 1'b1);   // 1*5 + 2*6
    repeat (4) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);
    issue(4'd2, 4'd0, 5'd2, 20'd39, 2, 1'b1);   // 3*5 + 4*6
    repeat (4) @(negedge clk);

    // length = 0: no reads, done in cycle 1, busy one cycle
    issue(4'd3, 4'd7, 5'd0, 20'd0, 0, 1'b1);
    check("t2_busy_c1", 32'(busy), 32'd1);
    check("t2_done_c1", 32'(done), 32'd1);
    @(negedge clk);
    check("t2_busy_c2", 32'(busy), 32'd0);
    check("t2_done_c2", 32'(done), 32'd0);

    // Full length of 0xFF operands
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'hFF;
    end
    @(negedge clk);
    issue(4'd0, 4'd0, 5'd16, exp_ff, 16, 1'b1);
    repeat (18) @(negedge clk);

    // Address wrap: A[14,15,0,1]={15,16,1,2}, B[2..5]={3,4,5,6} -> 126
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 1);
    end
    issue(4'd14, 4'd2, 5'd4, 20'd126, 4, 1'b1);
    repeat (6) @(negedge clk);

    // Operands with the top bit set
    mem_a[0] = 8'hFF;
    mem_a[1] = 8'hFE;
    mem_b[0] = 8'h03;
    mem_b[1] = 8'h04;
    issue(4'd0, 4'd0, 5'd2, exp_sgn, 2, 1'b1);
    repeat (4) @(negedge clk);

    // Reset in cycle 3 of a length-8 run: three reads issued, no done
    issue(4'd0, 4'd0, 5'd8, 20'd0, 3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_state",  32'(dbg_state), 32'd0);
    check("mrst_rd_en",  32'(rd_en), 32'd0);
    check("mrst_result", 32'(result), 32'd0);
    check("mrst_busy",   32'(busy), 32'd0);
    check("mrst_done",   32'(done), 32'd0);
    rst_n = 1'b0;
    repeat (12) @(negedge clk);
    check("mrst_idle_after", 32'(busy), 32'd0);

    // Every expected read and done must have been seen
    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("pending_reads",   32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Sequencer and multiply-accumulate stage directly downstream of the dot-product operand memories (vector A memory, vector B memory).
- On a start pulse it issues a run of read addresses to both memories in lockstep and consumes the registered read data, one element per cycle.
- It accumulates the element-wise products and presents the final dot product with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 8, operand width; matches memory data_out width.
- ADDR_WIDTH, 4, memory address width; the vector holds at most 2^ADDR_WIDTH elements.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH (20), accumulator and result width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-high; the name follows codebase convention, and asserted means reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_a  in  ADDR_WIDTH  first element address in memory A.
- base_b  in  ADDR_WIDTH  first element address in memory B.
- length  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH; sampled with start.
- rd_en  out  1  read enable, shared by both memories.
- rd_addr_a  out  ADDR_WIDTH  memory A read_address.
- rd_addr_b  out  ADDR_WIDTH  memory B read_address.
- rd_data_a  in  DATA_WIDTH  memory A data_out; registered, valid the cycle after rd_en.
- rd_data_b  in  DATA_WIDTH  memory B data_out; same timing as rd_data_a.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result is valid.
- result  out  ACC_WIDTH  final dot product; held until the next accepted start.

Behaviour:
- Reset (rst_n=1 at posedge): state=IDLE; rd_en=0; rd_addr_a=0; rd_addr_b=0; busy=0; done=0; result=0; accumulator=0; element counter=0; data-valid pipe flag=0.
- Reset applies from any state, including mid-run. Read data already in flight is discarded.
- States:
  - IDLE: start=1 with length>0 -> ISSUE. Latch base_a, base_b, length; clear accumulator.
  - IDLE: start=1 with length=0 -> DONE; result=0.
  - ISSUE: rd_en=1 for exactly length consecutive cycles. Element i drives rd_addr_a=base_a+i and rd_addr_b=base_b+i, both modulo 2^ADDR_WIDTH (wrap-around allowed). After the last issue -> DRAIN.
  - DRAIN: one cycle; consumes the final read data. -> DONE.
  - DONE: done=1 for one cycle; result=accumulator. -> IDLE.
- Data path:
  - The valid flag is rd_en delayed by 1 cycle.
  - When valid=1, accumulator += rd_data_a*rd_data_b.
  - Product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH.
  - Default ACC_WIDTH never overflows. A smaller override wraps modulo 2^ACC_WIDTH.
- Latency: start sampled at edge 0; rd_en high in cycles 1..N; done high in cycle N+2 (N=length). For length=0, done is high in cycle 1.
- busy: high in cycles 1..N+2. It drops to 0 in the cycle after done, and a new start is accepted in that cycle.
- start while not in IDLE is ignored, with no effect on the current run.
- rd_data_a/rd_data_b are ignored whenever valid=0. The memory data_out value at power-up is irrelevant.
- done and start may be back-to-back: start in the cycle after done launches a new run normally.

Optional Feature:
- Macro DOTP_SIGNED_EN.
- Defined: operands are two's-complement. The product is signed 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH; result is signed.
- Undefined: unsigned operands, zero-extended as above.
- Ports, latency and FSM are identical in both builds.

Test Plan:
- A[0..3]={1,2,3,4}, B[0..3]={5,6,7,8}, base 0/0, length=4: rd_en high 4 cycles; done in cycle 6; result=70.
- length=0, start: no rd_en; done in cycle 1; result=0; busy high 1 cycle.
- All 16 entries 0xFF in both memories, length=16: result=1040400 (0xFE010); no overflow.
- base_a=14, base_b=2, length=4: rd_addr_a=14,15,0,1 and rd_addr_b=2,3,4,5; result matches the software model.
- start pulsed again in cycle 2 of a length-4 run: ignored; single done; result unchanged vs. the undisturbed run. Then assert rst_n in cycle 3 of a new run: next cycle IDLE, rd_en=0, result=0, no done.
- DOTP_SIGNED_EN build, A={-1,-2}, B={3,4} (0xFF,0xFE / 0x03,0x04), length=2: result=-11 (0xFFFF5 at ACC_WIDTH=20).
